// File: rtl/lb_host_bridge_if.sv
// Byte-stream command/response link plus local-bus initiator signals of lb_host_bridge.
// The master modport is the bridge side; the slave modport is the host/cortex side.
interface lb_host_bridge_if #(
  parameter int unsigned LB_ADDR_W = 16,
  parameter int unsigned LB_DATA_W = 32
);
  logic                 cmd_valid;
  logic [7:0]           cmd_data;
  logic                 cmd_ready;
  logic                 rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_ready;
  logic                 lb_wr_en;
  logic                 lb_rd_en;
  logic [LB_ADDR_W-1:0] lb_addr;
  logic [LB_DATA_W-1:0] lb_wr_data;
  logic                 lb_wr_valid;
  logic                 lb_rd_valid;
  logic [LB_DATA_W-1:0] lb_rd_data;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, lb_wr_valid, lb_rd_valid, lb_rd_data,
    output cmd_ready, rsp_valid, rsp_data, lb_wr_en, lb_rd_en, lb_addr, lb_wr_data
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, lb_wr_valid, lb_rd_valid, lb_rd_data,
    input  cmd_ready, rsp_valid, rsp_data, lb_wr_en, lb_rd_en, lb_addr, lb_wr_data
  );
endinterface

// File: rtl/lb_host_bridge.sv
// Host-link to local-bus bridge: decodes framed byte commands into single LB
// writes/reads with a completion timeout and returns a framed byte response.
module lb_host_bridge #(
  parameter int unsigned          LB_DATA_W      = 32,
  parameter int unsigned          LB_ADDR_W      = 16,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter logic [LB_DATA_W-1:0] TIMEOUT_DATA   = LB_DATA_W'(32'hdeadbabe)
) (
  input  logic              clk,
  input  logic              rst_n,
  lb_host_bridge_if.master  bus,
  output logic              busy
);

  localparam int unsigned ADDR_BYTES = LB_ADDR_W / 8;
  localparam int unsigned DATA_BYTES = LB_DATA_W / 8;
  localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int unsigned TMR_W      = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RCNT_W     = $clog2(DATA_BYTES + 1);

  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_RD   = 8'h02;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, ISSUE, WAIT, RSP} state_t;

  state_t               state;
  logic                 op_rd;
  logic [CNT_W-1:0]     byte_cnt;
  logic [LB_ADDR_W-1:0] addr_sr;
  logic [LB_DATA_W-1:0] data_sr;
  logic [TMR_W-1:0]     tmr;
  logic [LB_DATA_W-1:0] rsp_buf;
  logic [RCNT_W-1:0]    rsp_cnt;

  logic                 cmd_fire;
  logic                 lb_done;
  logic                 expired;
  logic [LB_ADDR_W-1:0] addr_next;
  logic [LB_DATA_W-1:0] data_next;

  assign cmd_fire  = bus.cmd_valid & bus.cmd_ready;
  assign lb_done   = op_rd ? bus.lb_rd_valid : bus.lb_wr_valid;
  assign expired   = (state == WAIT) && (tmr == '0);
  assign addr_next = (addr_sr << 8) | LB_ADDR_W'(bus.cmd_data);
  assign data_next = (data_sr << 8) | LB_DATA_W'(bus.cmd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_rd          <= 1'b0;
      byte_cnt       <= '0;
      addr_sr        <= '0;
      data_sr        <= '0;
      tmr            <= '0;
      rsp_buf        <= '0;
      rsp_cnt        <= '0;
      busy           <= 1'b0;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.lb_wr_en   <= 1'b0;
      bus.lb_rd_en   <= 1'b0;
      bus.lb_addr    <= '0;
      bus.lb_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            busy     <= 1'b1;
            byte_cnt <= '0;
            if (bus.cmd_data == OP_WR) begin
              op_rd <= 1'b0;
              state <= ADDR;
            end else if (bus.cmd_data == OP_RD) begin
              op_rd <= 1'b1;
              state <= ADDR;
            end else begin
              state         <= RSP;
              bus.cmd_ready <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= RSP_ERR;
              rsp_cnt       <= '0;
            end
          end
        end

        ADDR: begin
          if (cmd_fire) begin
            addr_sr <= addr_next;
            if (byte_cnt == CNT_W'(ADDR_BYTES - 1)) begin
              byte_cnt <= '0;
              if (op_rd) begin
                state         <= ISSUE;
                bus.cmd_ready <= 1'b0;
                bus.lb_rd_en  <= 1'b1;
                bus.lb_addr   <= addr_next;
              end else begin
                state <= WDATA;
              end
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

        WDATA: begin
          if (cmd_fire) begin
            data_sr <= data_next;
            if (byte_cnt == CNT_W'(DATA_BYTES - 1)) begin
              byte_cnt       <= '0;
              state          <= ISSUE;
              bus.cmd_ready  <= 1'b0;
              bus.lb_wr_en   <= 1'b1;
              bus.lb_addr    <= addr_sr;
              bus.lb_wr_data <= data_next;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

        // Completion is accepted from the strobe cycle onward; valid beats expiry.
        ISSUE, WAIT: begin
          bus.lb_wr_en <= 1'b0;
          bus.lb_rd_en <= 1'b0;
          if (state == ISSUE) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES - 2);
          end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
          end
          if (lb_done || expired) begin
            state         <= RSP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= {(lb_done ? 4'hA : 4'hE), (op_rd ? 4'h2 : 4'h1)};
            rsp_buf       <= lb_done ? bus.lb_rd_data : TIMEOUT_DATA;
            rsp_cnt       <= op_rd ? RCNT_W'(DATA_BYTES) : '0;
          end else begin
            state <= WAIT;
          end
        end

        RSP: begin
          if (bus.rsp_ready) begin
            if (rsp_cnt == '0) begin
              state         <= IDLE;
              bus.rsp_valid <= 1'b0;
              bus.cmd_ready <= 1'b1;
              busy          <= 1'b0;
            end else begin
              bus.rsp_data <= rsp_buf[LB_DATA_W-1 -: 8];
              rsp_buf      <= rsp_buf << 8;
              rsp_cnt      <= rsp_cnt - RCNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_host_bridge.sv
// Directed bench for lb_host_bridge: host byte driver, delayed LB slave model,
// response monitor with stall-stability checks.
module tb_lb_host_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  lb_host_bridge_if #(.LB_ADDR_W(AW), .LB_DATA_W(DW)) bus ();

  lb_host_bridge #(
    .LB_DATA_W(DW), .LB_ADDR_W(AW), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hdeadbabe)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and stimulus knobs
  int          slv_delay = -1;
  logic [31:0] slv_rdata = '0;
  logic        slv_rd;
  int          inject_req = 0;
  int          inject_ack = 0;
  logic        rdy_toggle = 1'b0;

  initial begin
    bus.lb_wr_valid = 1'b0;
    bus.lb_rd_valid = 1'b0;
    bus.lb_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.lb_wr_en || bus.lb_rd_en) && slv_delay >= 0) begin
        slv_rd = bus.lb_rd_en;
        repeat (slv_delay) @(negedge clk);
        if (slv_rd) begin
          bus.lb_rd_valid = 1'b1;
          bus.lb_rd_data  = slv_rdata;
        end else begin
          bus.lb_wr_valid = 1'b1;
        end
        @(negedge clk);
        bus.lb_rd_valid = 1'b0;
        bus.lb_wr_valid = 1'b0;
      end else if (inject_req != inject_ack) begin
        bus.lb_rd_valid = 1'b1;
        bus.lb_rd_data  = 32'h99999999;
        @(negedge clk);
        bus.lb_rd_valid = 1'b0;
        inject_ack = inject_req;
      end
    end
  end

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.rsp_ready = rdy_toggle ? ~bus.rsp_ready : 1'b1;
    end
  end

  // Monitor: strobe capture, response collection, stall stability
  int          wr_pulses = 0;
  int          rd_pulses = 0;
  int          st_cyc = 0;
  int          rise_cyc = 0;
  logic [15:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic [7:0]  rsp_q[$];
  logic        prev_rv = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    #1;
    if (bus.lb_wr_en) begin
      wr_pulses++;
      st_cyc   = cyc;
      st_addr  = bus.lb_addr;
      st_wdata = bus.lb_wr_data;
    end
    if (bus.lb_rd_en) begin
      rd_pulses++;
      st_cyc  = cyc;
      st_addr = bus.lb_addr;
    end
    if (bus.rsp_valid && !prev_rv) rise_cyc = cyc;
    if (prev_stall && rst_n) check("rsp_hold", {bus.rsp_valid, bus.rsp_data}, {1'b1, prev_data});
    if (bus.rsp_valid) check("cmd_ready_in_rsp", bus.cmd_ready, 0);
    if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_data);
    prev_rv    = bus.rsp_valid;
    prev_stall = bus.rsp_valid && !bus.rsp_ready;
    prev_data  = bus.rsp_data;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("cmd_accept", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [55:0] bytes, input int len);
    for (int i = 0; i < len; i++) send_byte(bytes[8*(len-1-i) +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !bus.cmd_ready) && n < 300);
    check(tag, busy, 0);
  endtask

  task automatic check_rsp(input string tag, input logic [39:0] exp, input int len);
    logic [63:0] got;
    check({tag, "_len"}, rsp_q.size(), len);
    for (int i = 0; i < len; i++) begin
      got = (i < rsp_q.size()) ? 64'(rsp_q[i]) : 64'hFFFF;
      check($sformatf("%s_b%0d", tag, i), got, exp[8*(len-1-i) +: 8]);
    end
  endtask

  int w0;
  int r0;

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_strobes", {bus.lb_wr_en, bus.lb_rd_en}, 0);
    check("rst_busy", busy, 0);
    check("rst_lb_addr", bus.lb_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write, completion 3 cycles after strobe
    rsp_q.delete(); w0 = wr_pulses; slv_delay = 3;
    send_cmd(56'h01_1234_CAFEBABE, 7);
    wait_idle("wr_idle");
    check("wr_pulse", wr_pulses - w0, 1);
    check("wr_addr", st_addr, 16'h1234);
    check("wr_data", st_wdata, 32'hCAFEBABE);
    check_rsp("wr_rsp", 40'hA1, 1);
    check("wr_addr_hold", bus.lb_addr, 16'h1234);

    // Read, data 5 cycles after strobe
    rsp_q.delete(); r0 = rd_pulses; slv_delay = 5; slv_rdata = 32'h01020304;
    send_cmd(56'h02_0010, 3);
    wait_idle("rd_idle");
    check("rd_pulse", rd_pulses - r0, 1);
    check("rd_addr", st_addr, 16'h0010);
    check_rsp("rd_rsp", 40'hA2_01020304, 5);

    // Read timeout; slave answers late (during RSP) and again in IDLE
    rsp_q.delete(); slv_delay = 10;
    send_cmd(56'h02_ABCD, 3);
    wait_idle("to_idle");
    check("to_latency", rise_cyc - st_cyc, 8);
    check_rsp("to_rsp", 40'hE2_DEADBABE, 5);
    inject_req++;
    repeat (6) @(negedge clk);
    check("late_no_extra", rsp_q.size(), 5);
    check("late_busy", busy, 0);

    // Bad opcode
    rsp_q.delete(); w0 = wr_pulses; r0 = rd_pulses;
    send_byte(8'h7F);
    wait_idle("bad_idle");
    check_rsp("bad_rsp", 40'hEE, 1);
    check("bad_no_strobe", (wr_pulses - w0) + (rd_pulses - r0), 0);

    // Read under toggling rsp_ready
    rsp_q.delete(); slv_delay = 2; slv_rdata = 32'h11223344; rdy_toggle = 1'b1;
    send_cmd(56'h02_5566, 3);
    wait_idle("bp_idle");
    rdy_toggle = 1'b0;
    check("bp_addr", st_addr, 16'h5566);
    check_rsp("bp_rsp", 40'hA2_11223344, 5);

    // Reset after the 4th byte of a write
    rsp_q.delete(); w0 = wr_pulses; slv_delay = 3;
    send_cmd(56'h01_1234_CA, 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_en", bus.lb_wr_en, 0);
    check("mid_rst_lb_addr", bus.lb_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_pulse", wr_pulses - w0, 0);
    check("mid_rst_no_rsp", rsp_q.size(), 0);
    slv_delay = 5; slv_rdata = 32'h55AA00FF;
    send_cmd(56'h02_0010, 3);
    wait_idle("post_rst_idle");
    check_rsp("post_rst_rsp", 40'hA2_55AA00FF, 5);

    // Write completion on the expiry cycle: valid wins
    rsp_q.delete(); slv_delay = 7;
    send_cmd(56'h01_0004_00000001, 7);
    wait_idle("edge_idle");
    check_rsp("edge_rsp", 40'hA1, 1);

    // Zero-latency completion in the strobe cycle
    rsp_q.delete(); slv_delay = 0; slv_rdata = 32'hA5A5_0F0F;
    send_cmd(56'h02_FFFE, 3);
    wait_idle("zl_idle");
    check("zl_addr", st_addr, 16'hFFFE);
    check_rsp("zl_rsp", 40'hA2_A5A50F0F, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
